qproc_inport_fifo: RTL and testbench
====================================

Name: qproc_inport_fifo

Overview:
- Parametrised successor to the single-register input port stage of the qick processor.
- Each input port gets a DEPTH-entry FIFO, so back-to-back samples are no longer lost.
- Per-port status flags and a processor-driven pop handshake.
- Sits between external AXI-stream-like data ports and the processor's input-port read path.

Parameters:
- PORT_QTY, 2, number of input ports (1..16).
- DW, 64, data width per port.
- DEPTH, 4, entries per port FIFO; power of 2, 2..64.
- OVF_MODE, 0, policy on push into a full FIFO: 0 = drop new sample, 1 = overwrite oldest.

Ports:
- c_clk_i  in  1  processor clock.
- c_rst_ni  in  1  asynchronous active-low reset.
- c_clear  in  1  synchronous flush of all FIFOs and flags.
- port_tvalid_i  in  1 x PORT_QTY  per-port sample strobe.
- port_tdata_i  in  DW x PORT_QTY  per-port sample data.
- rd_en_i  in  1  processor pop request.
- rd_sel_i  in  $clog2(PORT_QTY) (min 1)  port selected for pop.
- port_tnew_o  out  PORT_QTY  per-port not-empty flag.
- port_tdata_o  out  DW x PORT_QTY  per-port FIFO head data.
- port_full_o  out  PORT_QTY  per-port full flag.
- port_ovf_o  out  PORT_QTY  per-port sticky overflow flag.
- port_cnt_o  out  ($clog2(DEPTH)+1) x PORT_QTY  per-port occupancy.

Behaviour:
- Clock and reset: one clock c_clk_i; reset is asynchronous and active-low (c_rst_ni).
- Reset values: all pointers, counts and flags 0; port_tnew_o=0, port_full_o=0, port_ovf_o=0, port_cnt_o=0, port_tdata_o=0. Memory contents are not reset; the head output is forced to 0 while empty.
- FIFO structure:
  - Per-port circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Separate occupancy counter cnt, 0..DEPTH.
  - port_tnew_o = (cnt!=0); port_full_o = (cnt==DEPTH).
- Push: port_tvalid_i[p]=1 and not full. Data is written at wr_ptr, wr_ptr increments, cnt increments.
- Pop: rd_en_i=1, rd_sel_i==p and cnt!=0. rd_ptr increments, cnt decrements.
  - rd_sel_i >= PORT_QTY: no effect.
  - Pop on an empty FIFO: ignored, no flag set.
- Latency:
  - A sample pushed in cycle N is visible on port_tdata_o/port_tnew_o in cycle N+1 if the FIFO was empty.
  - Pop in cycle N presents the next entry in cycle N+1.
- Simultaneous push+pop, same port:
  - Not full: both are performed; cnt unchanged.
  - Full: the pop frees the slot, the push is accepted, cnt stays DEPTH, no overflow.
  - Empty: the pop is ignored and the push is performed.
- Push when full with no pop:
  - OVF_MODE=0: sample discarded, port_ovf_o[p] set.
  - OVF_MODE=1: sample written at wr_ptr, both wr_ptr and rd_ptr advance, cnt stays DEPTH, port_ovf_o[p] set.
- port_ovf_o is sticky until c_clear or reset.
- c_clear:
  - Zeroes all pointers, cnt and ovf in the next cycle.
  - Takes priority over a same-cycle push/pop; that push is dropped.
- Ports are fully independent: pushes may occur on all ports in the same cycle; at most one pop per cycle.
- Reset mid-operation: immediate return to the reset state; no partial write completes.

Optional Feature:
- Macro: QPROC_INPORT_TSTAMP_EN.
- With the macro defined:
  - Added input t_time_i [47:0] and output port_ttime_o [48 x PORT_QTY].
  - Each pushed entry stores t_time_i sampled in the push cycle alongside the data.
  - port_ttime_o shows the head entry's timestamp, following identical FIFO/overwrite/clear rules.
  - It is 0 when the FIFO is empty.
- Without it: no timestamp storage and no timestamp ports.

Test Plan:
- Reset/empty: assert c_rst_ni=0 asynchronously mid-cycle -> all outputs 0 immediately. Pop on port 0 while empty -> cnt stays 0, ovf=0.
- Fill/drain (DEPTH=4, OVF_MODE=0): push 0x11,0x22,0x33,0x44 on port 1 -> full=1, cnt=4. Four pops -> head reads 0x11,0x22,0x33,0x44, then tnew=0.
- Overflow drop: with port 0 full of 1..4, push 5 -> ovf=1, cnt=4. Drain -> 1,2,3,4; ovf stays 1 until c_clear.
- Overwrite (OVF_MODE=1): with port 0 full of 1..4, push 5,6 -> ovf=1. Drain -> 3,4,5,6.
- Simultaneous events: port 0 full, push 9 plus pop on port 0 same cycle -> cnt=4, ovf=0, last entry 9. c_clear with a concurrent push on port 1 -> port 1 cnt=0 next cycle.
- Timestamp (macro on): push 0xAA at t_time_i=100 and 0xBB at t_time_i=107 -> heads return (0xAA,100), then (0xBB,107).

Source files
------------

// File: rtl/qproc_inport_fifo.sv
// Per-port input FIFOs with status flags and a processor-driven pop handshake.
// Optional head timestamps: define QPROC_INPORT_TSTAMP_EN.
module qproc_inport_fifo #(
   parameter  int PORT_QTY = 2,
   parameter  int DW       = 64,
   parameter  int DEPTH    = 4,
   parameter  int OVF_MODE = 0,
   localparam int SELW     = (PORT_QTY > 1) ? $clog2(PORT_QTY) : 1,
   localparam int PW       = $clog2(DEPTH),
   localparam int CW       = PW + 1
) (
   input  logic                   c_clk_i,
   input  logic                   c_rst_ni,
   input  logic                   c_clear,
   input  logic [PORT_QTY-1:0]    port_tvalid_i,
   input  logic [DW*PORT_QTY-1:0] port_tdata_i,
   input  logic                   rd_en_i,
   input  logic [SELW-1:0]        rd_sel_i,
`ifdef QPROC_INPORT_TSTAMP_EN
   input  logic [47:0]            t_time_i,
   output logic [48*PORT_QTY-1:0] port_ttime_o,
`endif
   output logic [PORT_QTY-1:0]    port_tnew_o,
   output logic [DW*PORT_QTY-1:0] port_tdata_o,
   output logic [PORT_QTY-1:0]    port_full_o,
   output logic [PORT_QTY-1:0]    port_ovf_o,
   output logic [CW*PORT_QTY-1:0] port_cnt_o
);

   logic [PORT_QTY-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PORT_QTY-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PORT_QTY-1:0][CW-1:0] cnt_q, cnt_d;
   logic [PORT_QTY-1:0]         ovf_q, ovf_d;
   logic [PORT_QTY-1:0]         wr_en;
   logic [PORT_QTY-1:0]         pop_ok;
   logic [PORT_QTY-1:0]         full;

   logic [DW-1:0] mem_q [PORT_QTY][DEPTH];
`ifdef QPROC_INPORT_TSTAMP_EN
   logic [47:0]   ts_mem_q [PORT_QTY][DEPTH];
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      wr_en    = '0;
      pop_ok   = '0;
      full     = '0;
      for (int p = 0; p < PORT_QTY; p++) begin
         full[p]   = (cnt_q[p] == CW'(DEPTH));
         pop_ok[p] = rd_en_i && (int'(rd_sel_i) == p) && (cnt_q[p] != '0);
         if (c_clear) begin
            wr_ptr_d[p] = '0;
            rd_ptr_d[p] = '0;
            cnt_d[p]    = '0;
            ovf_d[p]    = 1'b0;
         end else if (port_tvalid_i[p] && (!full[p] || pop_ok[p])) begin
            // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
            wr_en[p]    = 1'b1;
            wr_ptr_d[p] = wr_ptr_q[p] + PW'(1);
            if (pop_ok[p]) rd_ptr_d[p] = rd_ptr_q[p] + PW'(1);
            else           cnt_d[p]    = cnt_q[p] + CW'(1);
         end else if (port_tvalid_i[p]) begin
            ovf_d[p] = 1'b1;
            if (OVF_MODE != 0) begin
               wr_en[p]    = 1'b1;
               wr_ptr_d[p] = wr_ptr_q[p] + PW'(1);
               rd_ptr_d[p] = rd_ptr_q[p] + PW'(1);
            end
         end else if (pop_ok[p]) begin
            rd_ptr_d[p] = rd_ptr_q[p] + PW'(1);
            cnt_d[p]    = cnt_q[p] - CW'(1);
         end
      end
   end

   always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
      if (!c_rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is not reset; an empty FIFO masks its head to zero.
   always_ff @(posedge c_clk_i) begin
      for (int p = 0; p < PORT_QTY; p++) begin
         if (wr_en[p]) begin
            mem_q[p][wr_ptr_q[p]] <= port_tdata_i[p*DW +: DW];
`ifdef QPROC_INPORT_TSTAMP_EN
            ts_mem_q[p][wr_ptr_q[p]] <= t_time_i;
`endif
         end
      end
   end

   always_comb begin
      port_tnew_o  = '0;
      port_full_o  = '0;
      port_ovf_o   = '0;
      port_cnt_o   = '0;
      port_tdata_o = '0;
`ifdef QPROC_INPORT_TSTAMP_EN
      port_ttime_o = '0;
`endif
      for (int p = 0; p < PORT_QTY; p++) begin
         port_tnew_o[p]          = (cnt_q[p] != '0);
         port_full_o[p]          = full[p];
         port_ovf_o[p]           = ovf_q[p];
         port_cnt_o[p*CW +: CW]  = cnt_q[p];
         if (cnt_q[p] != '0) begin
            port_tdata_o[p*DW +: DW] = mem_q[p][rd_ptr_q[p]];
`ifdef QPROC_INPORT_TSTAMP_EN
            port_ttime_o[p*48 +: 48] = ts_mem_q[p][rd_ptr_q[p]];
`endif
         end
      end
   end

endmodule

// File: tb/tb_qproc_inport_fifo.sv
// Bench for qproc_inport_fifo: drop-mode and overwrite-mode instances share stimulus
// and are compared against a list-based reference model every cycle.
module tb_qproc_inport_fifo;
   localparam int PQ    = 2;
   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clr = 1'b0;
   logic [PQ-1:0]     vld = '0;
   logic [DW*PQ-1:0]  din = '0;
   logic              rd = 1'b0;
   logic              sel = 1'b0;

   logic [PQ-1:0]     tnew0, full0, ovf0, tnew1, full1, ovf1;
   logic [DW*PQ-1:0]  tdo0, tdo1;
   logic [CW*PQ-1:0]  cnt0, cnt1;
`ifdef QPROC_INPORT_TSTAMP_EN
   logic [47:0]       t_time = '0;
   logic [48*PQ-1:0]  tt0, tt1;
`endif

   always #5 clk = ~clk;

   qproc_inport_fifo #(.PORT_QTY(PQ), .DW(DW), .DEPTH(DEPTH), .OVF_MODE(0)) dut0 (
      .c_clk_i(clk), .c_rst_ni(rst_n), .c_clear(clr),
      .port_tvalid_i(vld), .port_tdata_i(din), .rd_en_i(rd), .rd_sel_i(sel),
`ifdef QPROC_INPORT_TSTAMP_EN
      .t_time_i(t_time), .port_ttime_o(tt0),
`endif
      .port_tnew_o(tnew0), .port_tdata_o(tdo0), .port_full_o(full0),
      .port_ovf_o(ovf0), .port_cnt_o(cnt0));

   qproc_inport_fifo #(.PORT_QTY(PQ), .DW(DW), .DEPTH(DEPTH), .OVF_MODE(1)) dut1 (
      .c_clk_i(clk), .c_rst_ni(rst_n), .c_clear(clr),
      .port_tvalid_i(vld), .port_tdata_i(din), .rd_en_i(rd), .rd_sel_i(sel),
`ifdef QPROC_INPORT_TSTAMP_EN
      .t_time_i(t_time), .port_ttime_o(tt1),
`endif
      .port_tnew_o(tnew1), .port_tdata_o(tdo1), .port_full_o(full1),
      .port_ovf_o(ovf1), .port_cnt_o(cnt1));

   // Reference model: each FIFO is an ordered list, index 0 = oldest.
   logic [63:0] m_dat [2][PQ][DEPTH];
   logic [47:0] m_ts  [2][PQ][DEPTH];
   int          m_cnt [2][PQ];
   bit          m_ovf [2][PQ];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] o_head(int m, int p);
      return (m == 0) ? tdo0[p*DW +: DW] : tdo1[p*DW +: DW];
   endfunction
   function automatic logic [63:0] o_cnt(int m, int p);
      return 64'((m == 0) ? cnt0[p*CW +: CW] : cnt1[p*CW +: CW]);
   endfunction
   function automatic logic [63:0] o_tnew(int m, int p);
      return 64'((m == 0) ? tnew0[p] : tnew1[p]);
   endfunction
   function automatic logic [63:0] o_full(int m, int p);
      return 64'((m == 0) ? full0[p] : full1[p]);
   endfunction
   function automatic logic [63:0] o_ovf(int m, int p);
      return 64'((m == 0) ? ovf0[p] : ovf1[p]);
   endfunction

   task automatic model_clear();
      for (int m = 0; m < 2; m++)
         for (int p = 0; p < PQ; p++) begin
            m_cnt[m][p] = 0;
            m_ovf[m][p] = 1'b0;
         end
   endtask

   task automatic list_drop_head(input int m, input int p);
      for (int i = 0; i < DEPTH - 1; i++) begin
         m_dat[m][p][i] = m_dat[m][p][i+1];
         m_ts[m][p][i]  = m_ts[m][p][i+1];
      end
      m_cnt[m][p]--;
   endtask

   task automatic list_append(input int m, input int p, input logic [63:0] d, input logic [47:0] t);
      m_dat[m][p][m_cnt[m][p]] = d;
      m_ts[m][p][m_cnt[m][p]]  = t;
      m_cnt[m][p]++;
   endtask

   task automatic model_step();
      logic [47:0] ts;
      ts = '0;
`ifdef QPROC_INPORT_TSTAMP_EN
      ts = t_time;
`endif
      for (int m = 0; m < 2; m++)
         for (int p = 0; p < PQ; p++) begin
            if (clr) begin
               m_cnt[m][p] = 0;
               m_ovf[m][p] = 1'b0;
               continue;
            end
            if (rd && int'(sel) == p && m_cnt[m][p] > 0) list_drop_head(m, p);
            if (vld[p]) begin
               if (m_cnt[m][p] < DEPTH) begin
                  list_append(m, p, din[p*DW +: DW], ts);
               end else begin
                  m_ovf[m][p] = 1'b1;
                  if (m == 1) begin
                     list_drop_head(m, p);
                     list_append(m, p, din[p*DW +: DW], ts);
                  end
               end
            end
         end
   endtask

   task automatic check_all(input string ph);
      for (int m = 0; m < 2; m++)
         for (int p = 0; p < PQ; p++) begin
            chk($sformatf("%s m%0d p%0d cnt", ph, m, p), o_cnt(m, p), 64'(m_cnt[m][p]));
            chk($sformatf("%s m%0d p%0d tnew", ph, m, p), o_tnew(m, p), 64'(m_cnt[m][p] != 0));
            chk($sformatf("%s m%0d p%0d full", ph, m, p), o_full(m, p), 64'(m_cnt[m][p] == DEPTH));
            chk($sformatf("%s m%0d p%0d ovf", ph, m, p), o_ovf(m, p), 64'(m_ovf[m][p]));
            chk($sformatf("%s m%0d p%0d head", ph, m, p), o_head(m, p),
                (m_cnt[m][p] != 0) ? m_dat[m][p][0] : 64'd0);
`ifdef QPROC_INPORT_TSTAMP_EN
            chk($sformatf("%s m%0d p%0d ts", ph, m, p),
                64'((m == 0) ? tt0[p*48 +: 48] : tt1[p*48 +: 48]),
                (m_cnt[m][p] != 0) ? 64'(m_ts[m][p][0]) : 64'd0);
`endif
         end
   endtask

   task automatic tick(input string ph, input logic [1:0] v, input logic [63:0] a,
                       input logic [63:0] b, input logic r, input logic s, input logic c);
      vld = v; din = {b, a}; rd = r; sel = s; clr = c;
      @(posedge clk);
      #1;
      model_step();
      check_all(ph);
      vld = '0; rd = 1'b0; clr = 1'b0;
   endtask

   initial begin : main
      logic [63:0] e_fill [4];
      logic [63:0] e_drop [4];
      logic [63:0] e_ovw  [4];
      logic [63:0] e_sim  [4];
      e_fill = '{64'h11, 64'h22, 64'h33, 64'h44};
      e_drop = '{64'd1, 64'd2, 64'd3, 64'd4};
      e_ovw  = '{64'd3, 64'd4, 64'd5, 64'd6};
      e_sim  = '{64'd2, 64'd3, 64'd4, 64'd9};

      // Reset and empty-pop
      model_clear();
      repeat (2) @(posedge clk);
      #1 check_all("reset");
      @(negedge clk) rst_n = 1'b1;
      tick("empty_pop", 2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
      chk("empty_pop cnt", o_cnt(0, 0), 64'd0);
      chk("empty_pop ovf", o_ovf(0, 0), 64'd0);

      // Fill and drain port 1
      for (int i = 0; i < 4; i++) tick("fill", 2'b10, 0, e_fill[i], 1'b0, 1'b0, 1'b0);
      chk("fill full", o_full(0, 1), 64'd1);
      chk("fill cnt", o_cnt(0, 1), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain head %0d", i), o_head(0, 1), e_fill[i]);
         tick("drain", 2'b00, 0, 0, 1'b1, 1'b1, 1'b0);
      end
      chk("drain tnew", o_tnew(0, 1), 64'd0);

      // Overflow: drop vs overwrite
      for (int i = 1; i <= 6; i++) tick("ovf_fill", 2'b01, 64'(i), 0, 1'b0, 1'b0, 1'b0);
      chk("ovf drop flag", o_ovf(0, 0), 64'd1);
      chk("ovf ovw flag", o_ovf(1, 0), 64'd1);
      chk("ovf ovw cnt", o_cnt(1, 0), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drop head %0d", i), o_head(0, 0), e_drop[i]);
         chk($sformatf("ovw head %0d", i), o_head(1, 0), e_ovw[i]);
         tick("ovf_drain", 2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
      end
      chk("ovf sticky", o_ovf(0, 0), 64'd1);
      tick("clear", 2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
      chk("ovf cleared", o_ovf(0, 0), 64'd0);

      // Push and pop on a full FIFO in the same cycle
      for (int i = 1; i <= 4; i++) tick("sim_fill", 2'b01, 64'(i), 0, 1'b0, 1'b0, 1'b0);
      tick("sim", 2'b01, 64'd9, 0, 1'b1, 1'b0, 1'b0);
      chk("sim cnt", o_cnt(0, 0), 64'd4);
      chk("sim ovf", o_ovf(0, 0), 64'd0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("sim head %0d", i), o_head(1, 0), e_sim[i]);
         tick("sim_drain", 2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
      end

      // Clear beats a concurrent push
      tick("pre_clr", 2'b10, 0, 64'h55, 1'b0, 1'b0, 1'b0);
      tick("clr_push", 2'b10, 0, 64'h77, 1'b0, 1'b0, 1'b1);
      chk("clr_push cnt", o_cnt(0, 1), 64'd0);

`ifdef QPROC_INPORT_TSTAMP_EN
      t_time = 48'd100;
      tick("ts_a", 2'b01, 64'hAA, 0, 1'b0, 1'b0, 1'b0);
      t_time = 48'd107;
      tick("ts_b", 2'b01, 64'hBB, 0, 1'b0, 1'b0, 1'b0);
      chk("ts head0", 64'(tt0[47:0]), 64'd100);
      tick("ts_pop", 2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
      chk("ts head1", 64'(tt0[47:0]), 64'd107);
      chk("ts data1", o_head(0, 0), 64'hBB);
`endif

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
`ifdef QPROC_INPORT_TSTAMP_EN
         t_time = 48'($urandom());
`endif
         tick("rand", 2'($urandom_range(0, 3)), {$urandom(), $urandom()}, {$urandom(), $urandom()},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      end

      // Asynchronous reset in mid-cycle
      for (int i = 1; i <= 3; i++) tick("pre_rst", 2'b11, 64'(i), 64'(i + 8), 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1 model_clear();
      check_all("async_rst");
      @(negedge clk) rst_n = 1'b1;
      tick("post_rst", 2'b01, 64'h5A, 0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
